// File: rtl/obtener_valores_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : obtener_valores_pwm
//  Purpose  : Turns a touch-panel (X, Y) sample into two PWM set-points.
//             The X coordinate picks a slider bar: the duty bar, the
//             frequency bar, or neither. The Y coordinate is scaled to a
//             percentage from 0 to 100. That percentage is then loaded
//             into the set-point that belongs to the selected bar.
//  Ports    : ADC_DCLK        - clock, shared with the touch ADC interface
//             RST_N           - asynchronous reset, active low
//             fin_transmision - high when a touch sample is complete;
//                               X_COORD and Y_COORD are valid while it is high
//             X_COORD[11:0]   - position across the bars (selects the bar)
//             Y_COORD[11:0]   - position along the bars (sets the value)
//             duty_cycle[6:0] - registered duty set-point, 0..100
//             freq_porcentaje[6:0] - registered frequency set-point, 0..100
//  Options  : OBTENER_PWM_EDGE_EN - when defined, only the first high cycle
//             of fin_transmision updates a set-point (rising-edge qualify).
//             When undefined, every high cycle updates (level qualify).
//  Revision : 1.0 - initial release
// ============================================================================
module obtener_valores_pwm #(
  parameter logic [11:0] X_DUTY_LO = 12'h733,
  parameter logic [11:0] X_DUTY_HI = 12'h9FF,
  parameter logic [11:0] X_FREQ_LO = 12'h199,
  parameter logic [11:0] X_FREQ_HI = 12'h4CC,
  parameter logic [6:0]  DUTY_RST  = 7'd50,
  parameter logic [6:0]  FREQ_RST  = 7'd50
) (
  input  logic        ADC_DCLK,
  input  logic        RST_N,
  input  logic        fin_transmision,
  input  logic [11:0] X_COORD,
  input  logic [11:0] Y_COORD,
  output logic [6:0]  duty_cycle,
  output logic [6:0]  freq_porcentaje
);

  localparam logic [18:0] c_SCALE   = 19'd100;
  localparam logic [18:0] c_ROUND   = 19'd2048;
  localparam logic [6:0]  c_PCT_MAX = 7'd100;

  logic [18:0] w_scaled;
  logic [6:0]  w_pct_raw;
  logic [6:0]  w_pct;
  logic        w_in_duty;
  logic        w_in_freq;
  logic        w_qual;

  // Y*100 + 2048 peaks at 411548, which fits in 19 bits. Adding 2048 before
  // the shift rounds to the nearest percent.
  assign w_scaled  = ({7'd0, Y_COORD} * c_SCALE) + c_ROUND;
  assign w_pct_raw = w_scaled[18:12];
  assign w_pct     = (w_pct_raw > c_PCT_MAX) ? c_PCT_MAX : w_pct_raw;

  assign w_in_duty = (X_COORD >= X_DUTY_LO) && (X_COORD <= X_DUTY_HI);
  assign w_in_freq = (X_COORD >= X_FREQ_LO) && (X_COORD <= X_FREQ_HI);

`ifdef OBTENER_PWM_EDGE_EN
  // r_fin_prev clears on reset. A fin_transmision that is already high
  // when reset releases therefore counts as a fresh touch.
  logic r_fin_prev;

  always_ff @(posedge ADC_DCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fin_prev <= 1'b0;
    end else begin
      r_fin_prev <= fin_transmision;
    end
  end

  assign w_qual = fin_transmision & ~r_fin_prev;
`else
  assign w_qual = fin_transmision;
`endif

  // The duty bar is tested first. If the two bands overlap, the duty bar
  // wins, and only one set-point changes per sample.
  always_ff @(posedge ADC_DCLK or negedge RST_N) begin
    if (!RST_N) begin
      duty_cycle      <= DUTY_RST;
      freq_porcentaje <= FREQ_RST;
    end else if (w_qual) begin
      if (w_in_duty) begin
        duty_cycle <= w_pct;
      end else if (w_in_freq) begin
        freq_porcentaje <= w_pct;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obtener_valores_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obtener_valores_pwm
//  Purpose  : Directed self-checking bench for obtener_valores_pwm.
//             The driver applies one vector per clock. After each rising
//             edge it queues the hand-computed {duty, freq} pair. A separate
//             monitor pops that pair on the falling edge and compares it
//             with the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obtener_valores_pwm;

  logic        clk;
  logic        rst_n;
  logic        fin;
  logic [11:0] x;
  logic [11:0] y;
  logic [6:0]  duty;
  logic [6:0]  freq;

  int n_vec;
  int n_err;
  logic [13:0] sb_q[$];

  obtener_valores_pwm dut (
    .ADC_DCLK        (clk),
    .RST_N           (rst_n),
    .fin_transmision (fin),
    .X_COORD         (x),
    .Y_COORD         (y),
    .duty_cycle      (duty),
    .freq_porcentaje (freq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs settle after the rising edge and are read on the
  // falling edge, half a cycle away from the active edge.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if ({duty, freq} !== e) begin
          n_err++;
          $display("FAIL vec%0d: got duty=%0d freq=%0d, expected duty=%0d freq=%0d",
                   n_vec, duty, freq, e[13:7], e[6:0]);
        end
      end
    end
  end

  // Applies one vector: inputs change on the falling edge, and the
  // expected result of the following rising edge is queued.
  task automatic drive(input logic f, input logic [11:0] xv, input logic [11:0] yv,
                       input int ed, input int ef);
    @(negedge clk);
    fin = f;
    x   = xv;
    y   = yv;
    @(posedge clk);
    sb_q.push_back({ed[6:0], ef[6:0]});
  endtask

  task automatic check_now(input string name, input int ed, input int ef);
    n_vec++;
    if (duty !== ed[6:0] || freq !== ef[6:0]) begin
      n_err++;
      $display("FAIL %s: got duty=%0d freq=%0d, expected duty=%0d freq=%0d",
               name, duty, freq, ed, ef);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  int exp_hold;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    fin   = 1'b0;
    x     = 12'h000;
    y     = 12'h000;

    // Reset acts before the first rising edge (time 5).
    #2 rst_n = 1'b0;
    #1 check_now("reset_async", 50, 50);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 12'h000, 12'h000, 50, 50);
    // Duty bar, 2-cycle pulse, Y=0x547 gives 33
    drive(1'b1, 12'h8CC, 12'h547, 33, 50);
    drive(1'b1, 12'h8CC, 12'h547, 33, 50);
    drive(1'b0, 12'h8CC, 12'h547, 33, 50);
    // Frequency bar, Y=0xBFF gives 75
    drive(1'b1, 12'h333, 12'hBFF, 33, 75);
    drive(1'b0, 12'h333, 12'hBFF, 33, 75);
    // Outside both bars
    drive(1'b1, 12'hB32, 12'h7FF, 33, 75);
    // Coordinates move while fin is low
    drive(1'b0, 12'h8CC, 12'hFFF, 33, 75);
    drive(1'b0, 12'h333, 12'h000, 33, 75);
    // Duty bar bounds and Y endpoints
    drive(1'b1, 12'h733, 12'hFFF, 100, 75);
    drive(1'b0, 12'h733, 12'hFFF, 100, 75);
    drive(1'b1, 12'h9FF, 12'h000, 0, 75);
    drive(1'b0, 12'h9FF, 12'h000, 0, 75);
    drive(1'b1, 12'hA00, 12'hFFF, 0, 75);
    drive(1'b0, 12'hA00, 12'hFFF, 0, 75);
    drive(1'b1, 12'h732, 12'hFFF, 0, 75);
    drive(1'b0, 12'h732, 12'hFFF, 0, 75);
    // Frequency bar bounds
    drive(1'b1, 12'h199, 12'h000, 0, 0);
    drive(1'b0, 12'h199, 12'h000, 0, 0);
    drive(1'b1, 12'h4CC, 12'h7FF, 0, 50);
    drive(1'b0, 12'h4CC, 12'h7FF, 0, 50);
    drive(1'b1, 12'h4CD, 12'hFFF, 0, 50);
    drive(1'b0, 12'h4CD, 12'hFFF, 0, 50);
    drive(1'b1, 12'h198, 12'hFFF, 0, 50);
    drive(1'b0, 12'h198, 12'hFFF, 0, 50);
    // Held high 3 cycles, Y moves on the second cycle
`ifdef OBTENER_PWM_EDGE_EN
    exp_hold = 33;
`else
    exp_hold = 100;
`endif
    drive(1'b1, 12'h8CC, 12'h547, 33, 50);
    drive(1'b1, 12'h8CC, 12'hFFF, exp_hold, 50);
    drive(1'b1, 12'h8CC, 12'hFFF, exp_hold, 50);
    drive(1'b0, 12'h8CC, 12'hFFF, exp_hold, 50);
    drain();

    // Mid-cycle reset with non-default values held. fin stays high through
    // the reset so that the first edge after release loads freq (Y=0xBFF -> 75).
    @(posedge clk);
    #2;
    fin   = 1'b1;
    x     = 12'h333;
    y     = 12'hBFF;
    rst_n = 1'b0;
    #1 check_now("reset_mid", 50, 50);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    sb_q.push_back({7'd50, 7'd75});
    drive(1'b0, 12'h333, 12'hBFF, 50, 75);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obtener_valores_pwm.md
# obtener_valores_pwm

Converts a touch-panel coordinate pair into two PWM set-points: duty cycle and frequency, each as a percentage from 0 to 100. The block sits between the touch-controller ADC interface and the PWM generator. Each touch lands on one of two horizontal slider bars drawn on the screen, and the position along the bar sets the value. Touches outside both bars leave both values unchanged.

## Interface
Parameters:
- `X_DUTY_LO`, default 12'h733 (45 %): lower X bound of the duty bar, inclusive.
- `X_DUTY_HI`, default 12'h9FF (62.5 %): upper X bound of the duty bar, inclusive.
- `X_FREQ_LO`, default 12'h199 (10 %): lower X bound of the frequency bar, inclusive.
- `X_FREQ_HI`, default 12'h4CC (30 %): upper X bound of the frequency bar, inclusive.
- `DUTY_RST`, default 7'd50: reset value of `duty_cycle`.
- `FREQ_RST`, default 7'd50: reset value of `freq_porcentaje`.

Ports:
- `ADC_DCLK`, input, 1 bit: the single clock, shared with the touch ADC interface. All logic is rising-edge.
- `RST_N`, input, 1 bit: asynchronous, active-low reset.
- `fin_transmision`, input, 1 bit: high means a touch sample is complete. `X_COORD` and `Y_COORD` are valid and stable while it is high.
- `X_COORD`, input, 12 bits: X coordinate, 0x000 to 0xFFF, measured across the bars. Selects which bar was touched.
- `Y_COORD`, input, 12 bits: Y coordinate, 0x000 to 0xFFF, measured along the bars. Sets the value.
- `duty_cycle`, output, 7 bits: registered duty set-point, 0 to 100.
- `freq_porcentaje`, output, 7 bits: registered frequency set-point, 0 to 100 % of the PWM generator's range.

## Operation
- **Percentage computation:** `pct = (Y_COORD*100 + 2048) >> 12`.
  - Use a 19-bit intermediate. Truncate the result to 7 bits.
  - Saturate at 100.
  - Y = 0x000 gives 0; Y = 0xFFF gives 100.
- **Zone decode** (comparisons are combinational and use inclusive bounds):
  - `X_DUTY_LO <= X_COORD <= X_DUTY_HI` selects the duty bar.
  - `X_FREQ_LO <= X_COORD <= X_FREQ_HI` selects the frequency bar.
  - Any other X selects no bar.
- **Update rule on a qualified sample:**
  - Duty zone: `duty_cycle <= pct`, and `freq_porcentaje` holds.
  - Frequency zone: `freq_porcentaje <= pct`, and `duty_cycle` holds.
  - No zone: both outputs hold.
- **Overlapping bands:** if the parameters make the two bands overlap, the duty bar takes priority. Only one output ever updates per sample.
- **Output changes:** outputs change only on a qualified sample, never at any other time. X and Y are ignored while `fin_transmision` is low.

## Timing
- **Reset:** while `RST_N` is low, asynchronously and immediately:
  - `duty_cycle = DUTY_RST` (50).
  - `freq_porcentaje = FREQ_RST` (50).
  - Internal edge register = 0.
- **Reset release:** takes effect on the next rising edge. Reset asserted mid-sample aborts the update.
- **Sampling and latency:** inputs are sampled at the `ADC_DCLK` rising edge. A qualified sample at edge N makes the new value visible after edge N, i.e. one-cycle latency. No busy or acknowledge signal exists.
- **Level-qualified mode (default):** every edge with `fin_transmision = 1` is a qualified sample. Holding it high for k cycles gives k updates. With stable coordinates the result is idempotent.
- **Pulse widths:** `fin_transmision` may be high for 1 or more cycles.
- **Coordinate changes:** coordinates changing while `fin_transmision` is low have no effect.

## Configuration
- **`OBTENER_PWM_EDGE_EN` defined:**
  - The block registers `fin_transmision`.
  - A qualified sample is only the edge where `fin_transmision = 1` and its previous registered value was 0. That gives exactly one update per touch, captured on its first high cycle.
  - Coordinate changes during the rest of the high period are ignored.
  - If `fin_transmision` is already high when reset releases, it counts as a new edge.
- **`OBTENER_PWM_EDGE_EN` undefined:** the level-qualified behaviour above applies, and no edge register is built.

## Test plan
1. **Reset:** assert `RST_N` = 0 mid-cycle -> `duty_cycle` = 50 and `freq_porcentaje` = 50 immediately, before any clock edge.
2. **Duty bar:** X = 0x8CC (55 %), Y = 0x547 (33 %), then `fin_transmision` pulsed 2 cycles -> `duty_cycle` = 33 one cycle after the first high edge; `freq_porcentaje` stays 50.
3. **Frequency bar:** X = 0x333 (20 %), Y = 0xBFF (75 %), pulse -> `freq_porcentaje` = 75; `duty_cycle` stays 33.
4. **Outside both bars:** X = 0xB32 (70 %), Y = 0x7FF, pulse -> both outputs unchanged (33, 75).
   - Changing X and Y with `fin_transmision` = 0 -> no change.
5. **Endpoints in the duty bar:**
   - Y = 0xFFF -> 100.
   - Y = 0x000 -> 0.
   - X = `X_DUTY_LO` and X = `X_DUTY_HI` are accepted.
   - X = `X_DUTY_HI` + 1 is ignored.
6. **Edge mode:** with `OBTENER_PWM_EDGE_EN`, hold `fin_transmision` high 3 cycles in the duty bar with Y moving 0x547 -> 0xFFF on cycle 2 -> `duty_cycle` = 33 only. Without the macro -> final value 100.
